// File: rtl/car_motion_scheduler.sv
// Per-frame car motion sequencer: on each frame_start, steps one car per cycle
// through its frame divider and advances its grid column when the divider expires.

module car_motion_lane #(
    parameter int         COLS = 20,
    parameter logic [4:0] INIT = 5'd0,
    parameter bit         DIR  = 1'b0,
    parameter logic [3:0] PER  = 4'd4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       restart,
    input  logic       step_en,
    input  logic [1:0] level,
    output logic [4:0] x
);
    logic [3:0] div;
    logic [3:0] eff;
    logic [4:0] div_inc;

    // Higher level shortens the period, but a car never stops moving entirely.
    always_comb begin
        eff     = (PER > {2'b00, level}) ? (PER - {2'b00, level}) : 4'd1;
        div_inc = {1'b0, div} + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x   <= INIT;
            div <= 4'd0;
        end else if (restart) begin
            x   <= INIT;
            div <= 4'd0;
        end else if (step_en) begin
            if (div_inc >= {1'b0, eff}) begin
                div <= 4'd0;
                if (DIR)
                    x <= (x == 5'(COLS - 1)) ? 5'd0 : x + 5'd1;
                else
                    x <= (x == 5'd0) ? 5'(COLS - 1) : x - 5'd1;
            end else begin
                div <= div_inc[3:0];
            end
        end
    end
endmodule

module car_motion_scheduler #(
    parameter int                      NUM_CARS = 16,
    parameter int                      COLS     = 20,
    parameter logic [5*NUM_CARS-1:0]   INIT_X   = {NUM_CARS{5'd0}},
    parameter logic [NUM_CARS-1:0]     DIR_MASK = '0,
    parameter logic [4*NUM_CARS-1:0]   PERIOD   = {NUM_CARS{4'd4}}
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    frame_start,
    input  logic                    freeze,
    input  logic                    restart,
    input  logic [1:0]              level,
    output logic [5*NUM_CARS-1:0]   car_x_flat,
    output logic                    busy,
    output logic                    update_done,
    output logic                    overrun
);
    localparam int IW = (NUM_CARS > 1) ? $clog2(NUM_CARS) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    state_t        state;
    logic [IW-1:0] idx;

    assign busy = (state == SCAN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            idx         <= '0;
            update_done <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            update_done <= 1'b0;
            if (frame_start && state != IDLE && !restart)
                overrun <= 1'b1;
            if (restart) begin
                state <= IDLE;
                idx   <= '0;
            end else begin
                case (state)
                    IDLE: if (frame_start && !freeze) begin
                        state <= SCAN;
                        idx   <= '0;
                    end
                    SCAN: if (idx == IW'(NUM_CARS - 1)) begin
                        state <= DONE;
                        idx   <= '0;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                    DONE: begin
                        update_done <= 1'b1;
                        state       <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    for (genvar i = 0; i < NUM_CARS; i++) begin : g_car
        car_motion_lane #(
            .COLS (COLS),
            .INIT (INIT_X[5*i +: 5]),
            .DIR  (DIR_MASK[i]),
            .PER  (PERIOD[4*i +: 4])
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .restart (restart),
            .step_en (state == SCAN && idx == IW'(i)),
            .level   (level),
            .x       (car_x_flat[5*i +: 5])
        );
    end
endmodule
